led_pwm_fader: RTL and testbench
================================

# led_pwm_fader

Downstream stage of the 4-LED chaser: consumes the chaser's active-low `led` pattern and drives the board LEDs with PWM, so that each LED ramps brightness up and down instead of switching hard. Sits between the chaser output and the LED pins. It contains a per-channel brightness level, a shared step prescaler and a shared PWM counter.

## Interface
- `PWM_BITS`, default 8: brightness resolution; PWM period = 2^PWM_BITS clocks (256 clocks, ~195 kHz at 50 MHz).
- `STEP_DIV`, default 39_062: clocks per brightness step; a full 0→max fade takes 255 × 39_062 clocks ≈ 0.2 s.
- `clk` in, 1: system clock, 50 MHz.
- `rst` in, 1: asynchronous, active-high reset.
- `led_in` in, 4: pattern from the chaser, active-low (0 = LED lit).
- `led_out` out, 4: PWM drive to the LED pins, active-low, registered.
- `busy` out, 1: high while any channel's level differs from its target, registered.

## Operation
- Input sync: `led_in` passes through two flops (`led_s`). Reset value is 4'b1111.
- Target per channel: MAX = 2^PWM_BITS−1 if `led_s[i]`==0, else 0.
- Step prescaler: counts 0..STEP_DIV−1 and wraps to 0. `tick` is asserted in the cycle the count equals STEP_DIV−1.
- Level update, only on `tick`:
  - level < target: level+1.
  - level > target: level−1.
  - Otherwise: hold.
  - Level saturates within [0, MAX] and never wraps.
- Target change mid-fade: the direction reverses on the next tick, continuing from the current level. There is no jump.
- PWM counter: free-running 0..MAX, wraps to 0. It is independent of the prescaler.
- Lit condition: lit[i] = (level[i]==MAX) or (level[i] > pwm_cnt). Level 0 is 0 % duty. Level MAX is 100 %. Level L is L/2^PWM_BITS duty.
- Output: `led_out[i]` <= ~lit[i].
- Busy: `busy` <= OR over i of (level[i] != target[i]).
- Reset (async, applied immediately):
  - Sync flops = 1111.
  - All levels = 0.
  - Prescaler = 0, PWM counter = 0.
  - `led_out` = 4'b1111 (all off).
  - `busy` = 0.
- After release, channels with target MAX fade up from 0.

## Timing
- Path from `led_in` to `led_s`: 2 cycles.
- First level step: occurs at the first `tick` after `led_s` changes, i.e. 0..STEP_DIV−1 further cycles.
- `level`/`pwm_cnt` → `led_out`: 1 cycle.
- `busy` rises 1 cycle after `led_s` changes the target. It falls 1 cycle after the final step.
- Full-scale fade: exactly MAX ticks = MAX × STEP_DIV clocks.
- Simultaneous tick and target change: the step uses the new target.

## Configuration
- `LED_PWM_FADE_EN` defined: full fade behaviour as above.
- `LED_PWM_FADE_EN` undefined:
  - Prescaler, levels and PWM counter are compiled out.
  - `led_out` <= `led_s`, giving a 3-cycle pure latency from `led_in`.
  - `busy` is tied to 0.
  - Reset values are unchanged.

## Test plan
All scenarios use PWM_BITS=4 and STEP_DIV=4 (MAX=15) unless noted.
- Reset: `rst`=1 with `led_in`=0000 → `led_out`=1111 and `busy`=0 throughout. Both stay so until release.
- Fade up: release reset with `led_in`=1110 → `busy`=1 from cycle 3. Level[0] increments every 4 clocks and reaches 15 after 60 ticks-worth of clocks. `led_out[0]` is then constantly 0 and `busy`=0. Channels 1..3 stay 1.
- Duty: hold level[0] at 5 (stop `led_in` toggling once reached) → `led_out[0]`=0 for exactly 5 of every 16 clocks.
- Reversal: when level[0]=8, set `led_in`=1111 → level goes 8,7,…,0 with no skip. `led_out[0]`=1 constantly at 0, then `busy`=0.
- Reset mid-fade: assert `rst` at level 7 → `led_out`=1111 in the same cycle (async). After release, the fade restarts from 0.
- Macro off: `led_in` 1111→1101 → `led_out`=1101 exactly 3 cycles later, with `busy`=0 always.

Source files
------------

// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if: pin-side bundle of the LED PWM fader.
//   led_in  : chaser pattern into the fader, active-low (0 = lit)
//   led_out : PWM drive to the LED pins, active-low
//   busy    : some channel is still fading toward its target
// master = producer of led_in / consumer of led_out, busy (chaser + board side)
// slave  = the fader itself
interface led_pwm_fader_if;
    logic [3:0] led_in;
    logic [3:0] led_out;
    logic       busy;

    modport master (output led_in, input led_out, input busy);
    modport slave  (input led_in, output led_out, output busy);
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: softens the 4-LED chaser by ramping each LED's PWM
// brightness up and down instead of switching it hard.
//   clk      : system clock
//   rst      : asynchronous, active-high reset
//   bus      : led_pwm_fader_if.slave (led_in, led_out, busy)
// Parameters: PWM_BITS (brightness resolution, period 2^PWM_BITS clocks),
//             STEP_DIV (clocks per one-level brightness step).
// Build option: define LED_PWM_FADE_EN to get the fading datapath; without
// it the block is a plain 3-flop delay from led_in to led_out, busy = 0.

`ifdef LED_PWM_FADE_EN
// One channel: brightness level walking one step per tick toward its target.
module led_pwm_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                off,      // synced led bit, 1 = LED dark
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                lit,
    output logic                differ
);
    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] target;

    assign target = off ? '0 : MAX;

    // Target is only ever 0 or MAX, so stepping toward it saturates for free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (tick) begin
            if (level < target)
                level <= level + 1'b1;
            else if (level > target)
                level <= level - 1'b1;
        end
    end

    // MAX is forced fully on; otherwise duty is level / 2^PWM_BITS.
    assign lit    = (level == MAX) || (level > pwm_cnt);
    assign differ = (level != target);
endmodule
`endif

module led_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 39_062
) (
    input  logic           clk,
    input  logic           rst,
    led_pwm_fader_if.slave bus
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] led_m;
    logic [NUM_LANES-1:0] led_s;

    // Two-flop synchroniser; reset to "all dark".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_m <= '1;
            led_s <= '1;
        end else begin
            led_m <= bus.led_in;
            led_s <= led_m;
        end
    end

`ifdef LED_PWM_FADE_EN
    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    logic [PRE_W-1:0]     pre;
    logic                 tick;
    logic [PWM_BITS-1:0]  pwm_cnt;
    logic [NUM_LANES-1:0] lit;
    logic [NUM_LANES-1:0] differ;

    assign tick = (pre == PRE_W'(STEP_DIV - 1));

    // Step prescaler and PWM counter run independently of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre     <= '0;
            pwm_cnt <= '0;
        end else begin
            pre     <= tick ? '0 : pre + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .off     (led_s[i]),
            .pwm_cnt (pwm_cnt),
            .lit     (lit[i]),
            .differ  (differ[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.led_out <= '1;
            bus.busy    <= 1'b0;
        end else begin
            bus.led_out <= ~lit;
            bus.busy    <= |differ;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.led_out <= '1;
        else
            bus.led_out <= led_s;
    end

    assign bus.busy = 1'b0;
`endif
endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader (PWM_BITS=4, STEP_DIV=4). Works with the fade
// datapath compiled in or out (LED_PWM_FADE_EN). A second instance with a
// slow step (STEP_DIV=64) holds a level long enough to measure PWM duty.
module tb_led_pwm_fader;
    localparam int PB  = 4;
    localparam int SD  = 4;
    localparam int SD2 = 64;
    localparam int MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    always #5 clk = ~clk;

    led_pwm_fader_if bus();
    led_pwm_fader_if bus2();

    led_pwm_fader #(.PWM_BITS(PB), .STEP_DIV(SD))  dut  (.clk(clk), .rst(rst),  .bus(bus));
    led_pwm_fader #(.PWM_BITS(PB), .STEP_DIV(SD2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: synced pattern as a 2-deep history, brightness as
    // plain integers, prescaler and PWM phase derived from the cycle count.
    logic [3:0] m_s1, m_s, m_out;
    logic       m_busy;
    int         m_lvl [4];
    int         m_cyc;

    task automatic model_reset();
        m_s1 = 4'hF; m_s = 4'hF; m_out = 4'hF; m_busy = 1'b0; m_cyc = 0;
        for (int i = 0; i < 4; i++) m_lvl[i] = 0;
    endtask

    task automatic model_edge(logic [3:0] li);
`ifdef LED_PWM_FADE_EN
        int pwm;
        bit tk;
        int tgt;
        logic [3:0] o;
        logic b;
        pwm = m_cyc % (MAX + 1);
        tk  = (m_cyc % SD) == SD - 1;
        o = 4'h0;
        b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tgt  = m_s[i] ? 0 : MAX;
            o[i] = !((m_lvl[i] == MAX) || (m_lvl[i] > pwm));
            if (m_lvl[i] != tgt) b = 1'b1;
            if (tk) begin
                if (m_lvl[i] < tgt) m_lvl[i] = m_lvl[i] + 1;
                else if (m_lvl[i] > tgt) m_lvl[i] = m_lvl[i] - 1;
            end
        end
        m_out = o;
        m_busy = b;
`else
        m_out = m_s;
        m_busy = 1'b0;
`endif
        m_s  = m_s1;
        m_s1 = li;
        m_cyc++;
    endtask

    // One clock: advance the model at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(bus.led_in);
        #1;
        check("led_out", bus.led_out, m_out);
        check("busy", bus.busy, m_busy);
    endtask

    // Asynchronous reset: outputs must go dark before any clock edge.
    task automatic do_reset(string name);
        rst = 1'b1;
        #1;
        check({name, "_out"}, bus.led_out, 4'hF);
        check({name, "_busy"}, bus.busy, 1'b0);
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_lvl0(int v, string name);
        int n;
        n = 0;
        while (m_lvl[0] != v && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: level %0d not reached within 300 cycles", name, v);
        end
    endtask

    typedef struct {
        logic [3:0] li;
        int         hold;
        logic [3:0] out;
        logic       busy;
        bit         chk_out;
    } vec_t;

    function automatic vec_t mk(logic [3:0] li, int hold, logic [3:0] out, logic busy, bit chk_out);
        vec_t v;
        v.li = li; v.hold = hold; v.out = out; v.busy = busy; v.chk_out = chk_out;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        int   hold;
        int   zeros;

`ifdef LED_PWM_FADE_EN
        tbl.push_back(mk(4'b0000, 80, 4'b0000, 1'b0, 1'b1));
        tbl.push_back(mk(4'b1111, 80, 4'b1111, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0110, 80, 4'b0110, 1'b0, 1'b1));
        tbl.push_back(mk(4'b1001,  3, 4'b0000, 1'b1, 1'b0));
        tbl.push_back(mk(4'b1001, 80, 4'b1001, 1'b0, 1'b1));
        tbl.push_back(mk(4'b1100,  2, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(4'b1100, 80, 4'b1100, 1'b0, 1'b1));
`else
        tbl.push_back(mk(4'b1111, 3, 4'b1111, 1'b0, 1'b1));
        tbl.push_back(mk(4'b1101, 2, 4'b1111, 1'b0, 1'b1));
        tbl.push_back(mk(4'b1101, 1, 4'b1101, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0000, 3, 4'b0000, 1'b0, 1'b1));
        tbl.push_back(mk(4'b1010, 2, 4'b0000, 1'b0, 1'b1));
        tbl.push_back(mk(4'b1010, 1, 4'b1010, 1'b0, 1'b1));
        tbl.push_back(mk(4'b0101, 3, 4'b0101, 1'b0, 1'b1));
`endif

        bus.led_in  = 4'b0000;
        bus2.led_in = 4'b1110;
        model_reset();

        // Held reset with all LEDs requested: stays dark, not busy.
        repeat (6) begin
            step();
            check("rst_out", bus.led_out, 4'hF);
            check("rst_busy", bus.busy, 1'b0);
        end

`ifdef LED_PWM_FADE_EN
        // Duty at level 5 on the slow instance: level k holds over edges
        // 64k+1..64k+64 after release, led_out one edge later.
        rst2 = 1'b0;
        zeros = 0;
        for (int n = 1; n <= 369; n++) begin
            @(posedge clk);
            #1;
            if (n >= 322 && !bus2.led_out[0]) zeros++;
        end
        check("duty_lvl5", zeros, 15);
        check("duty_busy", bus2.busy, 1'b1);

        // Fade up channel 0 from reset.
        bus.led_in = 4'b1110;
        rst = 1'b0;
        step();
        step();
        check("busy_pre", bus.busy, 1'b0);
        step();
        check("busy_rise", bus.busy, 1'b1);
        wait_lvl0(MAX, "fade_up");
        step();
        step();
        repeat (32) begin
            step();
            check("full_on", bus.led_out, 4'b1110);
            check("full_busy", bus.busy, 1'b0);
        end

        // Reset in the middle of a fade, then restart from 0.
        do_reset("rst_a");
        bus.led_in = 4'b1110;
        wait_lvl0(7, "to_7");
        do_reset("rst_mid");
        wait_lvl0(8, "to_8");

        // Reversal from level 8 down to 0.
        bus.led_in = 4'b1111;
        wait_lvl0(0, "fade_down");
        step();
        step();
        repeat (32) begin
            step();
            check("full_off", bus.led_out, 4'b1111);
            check("off_busy", bus.busy, 1'b0);
        end
`endif

        // Table of settled/boundary vectors.
        do_reset("rst_tbl");
        foreach (tbl[k]) begin
            bus.led_in = tbl[k].li;
            repeat (tbl[k].hold) step();
            if (tbl[k].chk_out) check($sformatf("tbl%0d_out", k), bus.led_out, tbl[k].out);
            check($sformatf("tbl%0d_busy", k), bus.busy, tbl[k].busy);
        end

        // Random patterns with occasional asynchronous resets.
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset("rst_rand");
            if (hold == 0) begin
                bus.led_in = 4'($urandom);
                hold = $urandom_range(1, 80);
            end
            hold--;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
